// File: rtl/sdram_bram_emu.sv
// sdram_bram_emu: SDR SDRAM device-side emulator backed by block RAM (BL1, CL2/3, per-bank rows).
// Rev 1.0
`default_nettype none

module sdram_bram_emu #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 9,
  parameter int TRCD     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] a,
  input  logic        dqml,
  input  logic        dqmh,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic [1:0]  dq_oe,
  output logic [12:0] mode_reg,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam int CW = $clog2(TRCD + 1);
  localparam logic [CW-1:0] TRCD_C = CW'(TRCD);

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic {B_IDLE = 1'b0, B_ACTIVE = 1'b1} bank_state_t;

  bank_state_t         bst  [4];
  logic [ROW_BITS-1:0] brow [4];
  logic [CW-1:0]       bcnt [4];
  logic                cl3;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rd_word;

  // Read pipeline: s1 = command captured, s2 = BRAM word out, s3 = extra CL3 stage
  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic [1:0]    s1_dqm;
  logic          s1_cl3;
  logic [1:0]    s2_oe;
  logic          s2_cl3;
  logic [1:0]    s3_oe;
  logic [15:0]   s3_word;

  logic [2:0]    cmd;
  logic          bank_open;
  logic          trcd_ok;
  logic          any_open;
  logic          wr_en;
  logic [AW-1:0] acc_addr;
  logic          mrs_ok;

  function automatic logic [15:0] lane_mask(input logic [1:0] oe);
    return {{8{oe[1]}}, {8{oe[0]}}};
  endfunction

  assign cmd       = cs_n ? CMD_NOP : {ras_n, cas_n, we_n};
  assign bank_open = (bst[ba] == B_ACTIVE);
  assign trcd_ok   = (bcnt[ba] >= TRCD_C);
  assign acc_addr  = {ba, brow[ba], a[COL_BITS-1:0]};
  assign wr_en     = (cmd == CMD_WR) && bank_open;
  assign mrs_ok    = (a[2:0] == 3'b000) && ((a[6:4] == 3'd2) || (a[6:4] == 3'd3));

  always_comb begin
    any_open = 1'b0;
    for (int i = 0; i < 4; i++)
      if (bst[i] == B_ACTIVE) any_open = 1'b1;
  end

  // Older CL3 data and newer CL2 data can only meet after a CL change; lanes are OR-merged.
  assign dq_oe = s3_oe | (s2_cl3 ? 2'b00 : s2_oe);
  assign dq_o  = s3_word | (s2_cl3 ? 16'h0000 : (rd_word & lane_mask(s2_oe)));

  always_ff @(posedge clk) begin
    if (wr_en && !dqml) mem[acc_addr][7:0]  <= dq_i[7:0];
    if (wr_en && !dqmh) mem[acc_addr][15:8] <= dq_i[15:8];
    rd_word <= mem[s1_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        bst[i]  <= B_IDLE;
        brow[i] <= '0;
        bcnt[i] <= '0;
      end
      cl3       <= 1'b0;
      mode_reg  <= 13'h020;
      proto_err <= 1'b0;
      err_code  <= 3'd0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_dqm    <= 2'b00;
      s1_cl3    <= 1'b0;
      s2_oe     <= 2'b00;
      s2_cl3    <= 1'b0;
      s3_oe     <= 2'b00;
      s3_word   <= 16'h0000;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bcnt[i] < TRCD_C) bcnt[i] <= bcnt[i] + 1'b1;

      s1_valid <= 1'b0;
      s2_oe    <= s1_valid ? ~s1_dqm : 2'b00;
      s2_cl3   <= s1_cl3;
      s3_oe    <= s2_cl3 ? s2_oe : 2'b00;
      s3_word  <= s2_cl3 ? (rd_word & lane_mask(s2_oe)) : 16'h0000;

      case (cmd)
        CMD_ACT: begin
          if (bank_open) begin
            proto_err <= 1'b1;
            err_code  <= 3'd2;
          end
          bst[ba]  <= B_ACTIVE;
          brow[ba] <= a[ROW_BITS-1:0];
          bcnt[ba] <= CW'(1);
        end
        CMD_PRE: begin
          if (a[10]) begin
            for (int i = 0; i < 4; i++) bst[i] <= B_IDLE;
          end else begin
            bst[ba] <= B_IDLE;
          end
        end
        CMD_RD, CMD_WR: begin
          if (!bank_open) begin
            proto_err <= 1'b1;
            err_code  <= 3'd1;
          end else begin
            if (!trcd_ok) begin
              proto_err <= 1'b1;
              err_code  <= 3'd3;
            end
            if ((cmd == CMD_WR) && (dq_oe != 2'b00)) begin
              proto_err <= 1'b1;
              err_code  <= 3'd6;
            end
            if (cmd == CMD_RD) begin
              s1_valid <= 1'b1;
              s1_addr  <= acc_addr;
              s1_dqm   <= {dqmh, dqml};
              s1_cl3   <= cl3;
            end
            if (a[10]) bst[ba] <= B_IDLE;
          end
        end
        CMD_REF: begin
          if (any_open) begin
            proto_err <= 1'b1;
            err_code  <= 3'd4;
          end
        end
        CMD_MRS: begin
          mode_reg <= a;
          if (mrs_ok) begin
            cl3 <= (a[6:4] == 3'd3);
          end else begin
            proto_err <= 1'b1;
            err_code  <= 3'd5;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_bram_emu.sv
// tb_sdram_bram_emu: directed + randomized command streams against a command-level SDRAM model.
`timescale 1ns/1ps

module tb_sdram_bram_emu;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 9;
  localparam int TRCD     = 2;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = 2'd0;
  logic [12:0] a = 13'd0;
  logic        dqml = 1'b0, dqmh = 1'b0;
  logic [15:0] dq_i = 16'd0;
  logic [15:0] dq_o;
  logic [1:0]  dq_oe;
  logic [12:0] mode_reg;
  logic        proto_err;
  logic [2:0]  err_code;

  sdram_bram_emu #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .TRCD(TRCD)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .a(a), .dqml(dqml), .dqmh(dqmh), .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe),
    .mode_reg(mode_reg), .proto_err(proto_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [1:0]  oe;
    logic [15:0] care;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;

  // Reference model state
  bit          m_open [4];
  int          m_row  [4];
  int          m_act  [4];
  int          m_cl;
  logic [12:0] m_mode;
  bit          m_perr;
  logic [2:0]  m_code;
  logic [7:0]  mem_lo [int];
  logic [7:0]  mem_hi [int];
  bit          busy   [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 0; m_row[i] = 0; m_act[i] = -100;
    end
    m_cl = 2; m_mode = 13'h020; m_perr = 0; m_code = 3'd0;
    sbq.delete();
    busy.delete();
  endtask

  task automatic model_err(input logic [2:0] code);
    m_perr = 1; m_code = code;
  endtask

  // One command per call; status from the previous command is checked first.
  task automatic cmd(input logic [2:0] c_in, input int b, input logic [12:0] ad,
                     input logic [1:0] dqm, input logic [15:0] d);
    logic [2:0] c;
    int n, key;
    exp_t e;
    bit anyo;
    c = c_in;
    @(negedge clk);
    check("err_code", 32'(err_code), 32'(m_code));
    check("proto_err", 32'(proto_err), 32'(m_perr));
    check("mode_reg", 32'(mode_reg), 32'(m_mode));
    n = cyc + 1;
    // Contention combined with another error has no single defined code; skip such writes.
    if (c == C_WR && busy.exists(n - 1) && (!m_open[b] || (n - m_act[b]) < TRCD)) c = C_NOP;
    cs_n = (c == C_NOP);
    {ras_n, cas_n, we_n} = c;
    ba = b[1:0]; a = ad; {dqmh, dqml} = dqm; dq_i = d;
    case (c)
      C_ACT: begin
        if (m_open[b]) model_err(3'd2);
        m_open[b] = 1; m_row[b] = int'(ad[ROW_BITS-1:0]); m_act[b] = n;
      end
      C_PRE: begin
        if (ad[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
        else m_open[b] = 0;
      end
      C_REF: begin
        anyo = 0;
        for (int i = 0; i < 4; i++) if (m_open[i]) anyo = 1;
        if (anyo) model_err(3'd4);
      end
      C_MRS: begin
        m_mode = ad;
        if (ad[2:0] == 3'b000 && (ad[6:4] == 3'd2 || ad[6:4] == 3'd3)) m_cl = int'(ad[6:4]);
        else model_err(3'd5);
      end
      C_RD, C_WR: begin
        if (!m_open[b]) model_err(3'd1);
        else begin
          if ((n - m_act[b]) < TRCD) model_err(3'd3);
          key = b * (1 << (ROW_BITS + COL_BITS)) + m_row[b] * (1 << COL_BITS) + int'(ad[COL_BITS-1:0]);
          if (c == C_WR) begin
            if (busy.exists(n - 1)) model_err(3'd6);
            if (!dqm[0]) mem_lo[key] = d[7:0];
            if (!dqm[1]) mem_hi[key] = d[15:8];
          end else begin
            e.due = n + m_cl - 1; e.oe = ~dqm; e.data = 16'h0; e.care = 16'h0;
            if (dqm[0]) e.care[7:0] = 8'hFF;
            else if (mem_lo.exists(key)) begin e.data[7:0] = mem_lo[key]; e.care[7:0] = 8'hFF; end
            if (dqm[1]) e.care[15:8] = 8'hFF;
            else if (mem_hi.exists(key)) begin e.data[15:8] = mem_hi[key]; e.care[15:8] = 8'hFF; end
            if (e.oe != 2'b00) begin
              sbq.push_back(e);
              busy[e.due] = 1;
            end
          end
          if (ad[10]) m_open[b] = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic nop(input int k);
    for (int i = 0; i < k; i++) cmd(C_NOP, 0, 13'h0, 2'b00, 16'h0);
  endtask

  // Monitor / scoreboard
  exp_t mon_e;
  always @(negedge clk) begin
    if (started) begin
      if (!rst_n) begin
        check("oe_in_reset", 32'(dq_oe), 32'd0);
      end else if (dq_oe != 2'b00) begin
        if (sbq.size() == 0) check("unexpected_oe", 32'(dq_oe), 32'd0);
        else begin
          mon_e = sbq.pop_front();
          check("rd_cycle", 32'(cyc), 32'(mon_e.due));
          check("rd_oe", 32'(dq_oe), 32'(mon_e.oe));
          check("rd_data", 32'(dq_o & mon_e.care), 32'(mon_e.data & mon_e.care));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        check("rd_missing", 32'(dq_oe), 32'(mon_e.oe));
      end
    end
  end

  task automatic async_reset_mid_cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cs_n = 1'b1;
    model_reset();
    #1;
    check("arst_oe", 32'(dq_oe), 32'd0);
    check("arst_dq", 32'(dq_o), 32'd0);
    check("arst_perr", 32'(proto_err), 32'd0);
    check("arst_code", 32'(err_code), 32'd0);
    check("arst_mode", 32'(mode_reg), 32'h020);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int count);
    int r, b;
    logic [12:0] ad;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 9);
      b = $urandom_range(0, 3);
      ad = 13'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 13'h400 : 13'h0)
         | (($urandom_range(0, 1) == 1) ? 13'h200 : 13'h0);
      case (r)
        0, 1:    cmd(C_ACT, b, 13'($urandom), 2'b00, 16'h0);
        2:       cmd(C_PRE, b, ($urandom_range(0, 3) == 0) ? 13'h400 : 13'h0, 2'b00, 16'h0);
        3, 4, 5: cmd(C_RD, b, ad, 2'($urandom_range(0, 3)), 16'h0);
        6, 7, 8: cmd(C_WR, b, ad, 2'($urandom_range(0, 3)), 16'($urandom));
        default: cmd(($urandom_range(0, 1) == 1) ? C_REF : C_NOP, b, 13'h0, 2'b00, 16'h0);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    started = 1;
    repeat (3) @(negedge clk);
    check("reset_oe", 32'(dq_oe), 32'd0);
    check("reset_mode", 32'(mode_reg), 32'h020);
    check("reset_perr", 32'(proto_err), 32'd0);
    check("reset_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;

    // Basic write/read with auto-precharge, CL2
    cmd(C_MRS, 0, 13'h220, 2'b00, 16'h0);
    cmd(C_ACT, 1, 13'h5, 2'b00, 16'h0);
    nop(2);
    cmd(C_WR, 1, 13'h4A3, 2'b00, 16'hBEEF);
    cmd(C_ACT, 1, 13'h5, 2'b00, 16'h0);
    nop(2);
    cmd(C_RD, 1, 13'h4A3, 2'b00, 16'h0);
    nop(3);
    check("t2_perr", 32'(proto_err), 32'd0);

    // Byte masks: ACT without error proves bank1 was closed by auto-precharge
    cmd(C_ACT, 1, 13'h5, 2'b00, 16'h0);
    nop(1);
    check("t3_act_code", 32'(err_code), 32'd0);
    nop(1);
    cmd(C_WR, 1, 13'h0A3, 2'b10, 16'h1234);
    nop(1);
    cmd(C_RD, 1, 13'h0A3, 2'b01, 16'h0);
    cmd(C_RD, 1, 13'h4A3, 2'b00, 16'h0);
    nop(3);

    // Idle-bank access and tRCD violation
    cmd(C_RD, 2, 13'h005, 2'b00, 16'h0);
    nop(1);
    check("t4_idle_code", 32'(err_code), 32'd1);
    check("t4_idle_perr", 32'(proto_err), 32'd1);
    cmd(C_ACT, 2, 13'h7, 2'b00, 16'h0);
    cmd(C_RD, 2, 13'h005, 2'b00, 16'h0);
    nop(1);
    check("t4_trcd_code", 32'(err_code), 32'd3);
    nop(3);

    // CL3 and a rejected MRS that must leave CL at 3
    cmd(C_PRE, 0, 13'h400, 2'b00, 16'h0);
    cmd(C_MRS, 0, 13'h230, 2'b00, 16'h0);
    cmd(C_ACT, 0, 13'h0, 2'b00, 16'h0);
    nop(2);
    cmd(C_WR, 0, 13'h010, 2'b00, 16'hC0DE);
    nop(1);
    cmd(C_RD, 0, 13'h010, 2'b00, 16'h0);
    nop(4);
    cmd(C_MRS, 0, 13'h250, 2'b00, 16'h0);
    nop(1);
    check("t5_badmrs_code", 32'(err_code), 32'd5);
    check("t5_badmrs_mode", 32'(mode_reg), 32'h250);
    cmd(C_RD, 0, 13'h010, 2'b00, 16'h0);
    nop(4);

    // REF with an open bank, then reset while a CL3 read is in flight
    cmd(C_PRE, 0, 13'h400, 2'b00, 16'h0);
    cmd(C_ACT, 0, 13'h0, 2'b00, 16'h0);
    nop(1);
    cmd(C_REF, 0, 13'h0, 2'b00, 16'h0);
    nop(1);
    check("t6_ref_code", 32'(err_code), 32'd4);
    nop(1);
    cmd(C_RD, 0, 13'h010, 2'b00, 16'h0);
    async_reset_mid_cycle();
    nop(2);

    // Randomized traffic at CL2 then CL3
    rand_phase(300);
    nop(4);
    cmd(C_MRS, 0, 13'h030, 2'b00, 16'h0);
    rand_phase(300);
    nop(6);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
